ip_header_tx: RTL and testbench



---
 rtl/ip_pkg.sv | 42 ++++
 rtl/ip_hdr_word_sel.sv | 40 ++++
 rtl/ip_header_tx.sv | 164 ++++++++++++++++
 tb/tb_ip_header_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_pkg.sv
// Shared IPv4 header definitions.
//
// Provides the fixed header constants, the TX sequencer state type, the
// latched per-packet field bundle and the one's-complement helpers that the
// TX header generator and the RX checksum path both use.
package ip_pkg;

  localparam logic [7:0]  IP_VER_IHL   = 8'h45;  // version 4, IHL 5 (no options)
  localparam int unsigned IP_HDR_BYTES = 20;
  localparam int unsigned IP_HDR_WORDS = 10;

  typedef enum logic [1:0] {
    StIdle,
    StSum,
    StSend,
    StDone
  } ip_tx_state_e;

  // Per-packet fields captured on start. total_len is stored already biased
  // by the header length so the word selector stays purely combinational.
  typedef struct packed {
    logic [15:0] total_len;
    logic [15:0] ident;
    logic [7:0]  protocol;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } ip_hdr_fields_t;

  // One step of the 16-bit one's-complement sum. The carry from the previous
  // step is folded back in together with the new word, so the 17-bit
  // accumulator never needs more than one carry bit.
  function automatic logic [16:0] ones_comp_add(input logic [16:0] acc,
                                                input logic [15:0] word);
    return {1'b0, acc[15:0]} + {16'b0, acc[16]} + {1'b0, word};
  endfunction

  // Final fold of the pending carry and inversion into the header checksum.
  function automatic logic [15:0] ones_comp_csum(input logic [16:0] acc);
    return ~(acc[15:0] + {15'b0, acc[16]});
  endfunction

endpackage

// File: rtl/ip_hdr_word_sel.sv
// IPv4 header word selector.
//
// Maps a header word index (0..9) and the latched packet fields to the
// corresponding 16-bit header word. Word 5 (checksum) is returned as zero;
// the transmitter substitutes the stored checksum when serialising.
//
// Ports:
//   word_idx  in  4   header word index, 0..9 (others return zero)
//   fields    in  -   latched per-packet fields
//   word      out 16  selected header word
module ip_hdr_word_sel
  import ip_pkg::*;
#(
  parameter logic [7:0] TTL = 8'd64,
  parameter logic [7:0] TOS = 8'h00,
  parameter logic       DF  = 1'b1
) (
  input  logic [3:0]     word_idx,
  input  ip_hdr_fields_t fields,
  output logic [15:0]    word
);

  always_comb begin
    word = 16'h0000;
    case (word_idx)
      4'd0:    word = {IP_VER_IHL, TOS};
      4'd1:    word = fields.total_len;
      4'd2:    word = fields.ident;
      4'd3:    word = {1'b0, DF, 14'b0};         // flags + zero fragment offset
      4'd4:    word = {TTL, fields.protocol};
      4'd5:    word = 16'h0000;                  // checksum slot, summed as zero
      4'd6:    word = fields.src_ip[31:16];
      4'd7:    word = fields.src_ip[15:0];
      4'd8:    word = fields.dst_ip[31:16];
      4'd9:    word = fields.dst_ip[15:0];
      default: word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/ip_header_tx.sv
// IPv4 header transmitter.
//
// On start (sampled in idle) latches the packet fields, spends ten cycles
// summing the header words into a one's-complement checksum, then streams
// the 20-byte header MSB-first on a valid/ready byte interface and pulses
// done for one cycle after the final byte is accepted.
//
// Ports:
//   clk          in  1   system clock
//   rst          in  1   synchronous active-high reset, aborts any packet
//   start        in  1   single-cycle request, ignored unless idle
//   payload_len  in  16  bytes following the IP header
//   ident        in  16  identification field
//   protocol     in  8   IP protocol number
//   src_ip       in  32  source address
//   dst_ip       in  32  destination address
//   busy         out 1   high whenever not idle
//   byte_out     out 8   header byte (zero when not valid)
//   byte_valid   out 1   byte_out valid
//   byte_ready   in  1   downstream accept
//   byte_last    out 1   high with header byte 19
//   done         out 1   one-cycle pulse after the final transfer
module ip_header_tx
  import ip_pkg::*;
#(
  parameter logic [7:0] TTL = 8'd64,
  parameter logic [7:0] TOS = 8'h00,
  parameter logic       DF  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] payload_len,
  input  logic [15:0] ident,
  input  logic [7:0]  protocol,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  output logic        busy,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        byte_last,
  output logic        done
);

  localparam logic [3:0]  LastWord  = 4'(IP_HDR_WORDS - 1);
  localparam logic [4:0]  LastByte  = 5'(IP_HDR_BYTES - 1);
  localparam logic [3:0]  CsumWord  = 4'd5;
  localparam logic [15:0] HdrLenB   = 16'(IP_HDR_BYTES);

  ip_tx_state_e   state_q, state_d;
  ip_hdr_fields_t fields_q, fields_d;
  logic [16:0]    acc_q, acc_d;
  logic [3:0]     sum_idx_q, sum_idx_d;
  logic [4:0]     byte_cnt_q, byte_cnt_d;
  logic [15:0]    csum_q, csum_d;

  logic [3:0]     word_idx;
  logic [15:0]    sel_word;
  logic [15:0]    tx_word;
  logic [16:0]    acc_sum;
  logic           xfer;

  // One selector serves both phases: the sum walks words by cycle, the
  // sender walks them by byte pair.
  assign word_idx = (state_q == StSend) ? byte_cnt_q[4:1] : sum_idx_q;

  ip_hdr_word_sel #(
    .TTL (TTL),
    .TOS (TOS),
    .DF  (DF)
  ) u_word_sel (
    .word_idx (word_idx),
    .fields   (fields_q),
    .word     (sel_word)
  );

  // The selector yields zero for the checksum slot; that zero is what the
  // sum needs, and on the wire the stored checksum replaces it.
  assign tx_word = (byte_cnt_q[4:1] == CsumWord) ? csum_q : sel_word;
  assign acc_sum = ones_comp_add(acc_q, sel_word);

  assign busy       = (state_q != StIdle);
  assign byte_valid = (state_q == StSend);
  assign xfer       = byte_valid & byte_ready;
  assign byte_last  = byte_valid & (byte_cnt_q == LastByte);
  assign done       = (state_q == StDone);

  // Outputs come straight from registered state, so they hold stable
  // through any stall without extra holding registers.
  always_comb begin
    byte_out = 8'h00;
    if (byte_valid) begin
      byte_out = byte_cnt_q[0] ? tx_word[7:0] : tx_word[15:8];
    end
  end

  always_comb begin
    state_d    = state_q;
    fields_d   = fields_q;
    acc_d      = acc_q;
    sum_idx_d  = sum_idx_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          fields_d.total_len = payload_len + HdrLenB;  // wraps modulo 2^16
          fields_d.ident     = ident;
          fields_d.protocol  = protocol;
          fields_d.src_ip    = src_ip;
          fields_d.dst_ip    = dst_ip;
          acc_d              = '0;
          sum_idx_d          = '0;
          byte_cnt_d         = '0;
          state_d            = StSum;
        end
      end
      StSum: begin
        acc_d     = acc_sum;
        sum_idx_d = sum_idx_q + 4'd1;
        if (sum_idx_q == LastWord) begin
          csum_d  = ones_comp_csum(acc_sum);
          state_d = StSend;
        end
      end
      StSend: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 5'd1;
          if (byte_cnt_q == LastByte) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // start is deliberately not looked at here.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fields_q   <= '0;
      acc_q      <= '0;
      sum_idx_q  <= '0;
      byte_cnt_q <= '0;
      csum_q     <= '0;
    end else begin
      state_q    <= state_d;
      fields_q   <= fields_d;
      acc_q      <= acc_d;
      sum_idx_q  <= sum_idx_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
    end
  end

endmodule

// File: tb/tb_ip_header_tx.sv
// Self-checking bench for ip_header_tx.
//
// A header model computes the 20 expected bytes from the packet fields with
// plain 32-bit arithmetic; a negedge monitor compares every offered byte,
// byte_last and stall stability against it. Directed sequences pin latency,
// literal header bytes, backpressure, ignored starts and reset abort.
module tb_ip_header_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] payload_len;
  logic [15:0] ident;
  logic [7:0]  protocol;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic        busy;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        byte_last;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_hdr [20];
  logic [7:0] cap     [20];
  logic [7:0] ref_bytes [20];
  int         mon_pos    = 0;
  int         xfers      = 0;
  int         done_count = 0;

  always #5 clk = ~clk;

  ip_header_tx dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .payload_len (payload_len),
    .ident       (ident),
    .protocol    (protocol),
    .src_ip      (src_ip),
    .dst_ip      (dst_ip),
    .busy        (busy),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .byte_last   (byte_last),
    .done        (done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Header model: sum all ten words in 32 bits, fold carries, invert.
  task automatic fill_expected(input logic [15:0] plen, input logic [15:0] id,
                               input logic [7:0] proto, input logic [31:0] src,
                               input logic [31:0] dst);
    logic [15:0] w [10];
    logic [31:0] sum;
    w[0] = 16'h4500;
    w[1] = plen + 16'd20;
    w[2] = id;
    w[3] = 16'h4000;
    w[4] = {8'd64, proto};
    w[5] = 16'h0000;
    w[6] = src[31:16];
    w[7] = src[15:0];
    w[8] = dst[31:16];
    w[9] = dst[15:0];
    sum = 32'd0;
    for (int i = 0; i < 10; i++) sum = sum + {16'd0, w[i]};
    while (sum > 32'h0000_FFFF) sum = (sum & 32'h0000_FFFF) + (sum >> 16);
    w[5] = ~sum[15:0];
    for (int i = 0; i < 20; i++) exp_hdr[i] = (i % 2 == 1) ? w[i/2][7:0] : w[i/2][15:8];
  endtask

  task automatic send_start(input logic [15:0] plen, input logic [15:0] id,
                            input logic [7:0] proto, input logic [31:0] src,
                            input logic [31:0] dst, input bit accept);
    payload_len = plen;
    ident       = id;
    protocol    = proto;
    src_ip      = src;
    dst_ip      = dst;
    start       = 1'b1;
    if (accept) begin
      fill_expected(plen, id, proto, src, dst);
      mon_pos    = 0;
      xfers      = 0;
      done_count = 0;
    end
    tick();
    start       = 1'b0;
    payload_len = 16'($urandom);
    ident       = 16'($urandom);
    protocol    = 8'($urandom);
    src_ip      = $urandom;
    dst_ip      = $urandom;
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    while (!done && cycles < limit) begin
      tick();
      cycles++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  // Compare process: every offered byte against the model, stall stability.
  initial begin : monitor
    logic       stalled;
    logic [8:0] held;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst && byte_valid) begin
        if (stalled) check("stall_hold", {23'd0, byte_last, byte_out}, {23'd0, held});
        if (byte_ready) begin
          if (mon_pos < 20) begin
            check($sformatf("byte%0d", mon_pos), {23'd0, byte_last, byte_out},
                  {23'd0, (mon_pos == 19), exp_hdr[mon_pos]});
            cap[mon_pos] = byte_out;
          end else begin
            check("extra_byte", 32'(mon_pos), 32'd19);
          end
          mon_pos++;
          xfers++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = {byte_last, byte_out};
        end
      end else begin
        stalled = 1'b0;
      end
      if (!rst && done) done_count++;
    end
  end

  initial begin : stimulus
    int lat;
    int cyc;
    ref_bytes = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                  8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
    rst = 1'b1; start = 1'b0; byte_ready = 1'b1;
    payload_len = '0; ident = '0; protocol = '0; src_ip = '0; dst_ip = '0;
    for (int i = 0; i < 20; i++) exp_hdr[i] = 8'h00;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(byte_valid), 32'd0);
    check("rst_last", 32'(byte_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_byte", 32'(byte_out), 32'd0);
    rst = 1'b0;
    tick();

    // Reference header, ready held high.
    send_start(16'd95, 16'h0000, 8'h11, 32'hC0A8_0001, 32'hC0A8_00C7, 1'b1);
    check("model_csum_hi", 32'(exp_hdr[10]), 32'hB8);
    check("model_csum_lo", 32'(exp_hdr[11]), 32'h61);
    lat = 1;
    while (!byte_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("first_valid_latency", 32'(lat), 32'd11);
    cyc = lat;
    while (!done && cyc < 80) begin
      if (!byte_valid) check("bubble", 32'(byte_valid), 32'd1);
      tick();
      cyc++;
    end
    check("start_to_done", 32'(cyc), 32'd31);
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("done_pulse_len", 32'(done), 32'd0);
    check("ref_done_count", 32'(done_count), 32'd1);
    check("ref_xfers", 32'(xfers), 32'd20);
    for (int i = 0; i < 20; i++) check($sformatf("ref_lit%0d", i), 32'(cap[i]), 32'(ref_bytes[i]));

    // Carry folding.
    send_start(16'd0, 16'hFFFF, 8'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(100, cyc);
    tick();
    check("carry_csum_hi", 32'(cap[10]), 32'h3A);
    check("carry_csum_lo", 32'(cap[11]), 32'hDA);

    // Zero addresses.
    send_start(16'd0, 16'h0000, 8'h06, 32'h0, 32'h0, 1'b1);
    wait_done(100, cyc);
    tick();
    check("zero_len_hi", 32'(cap[2]), 32'h00);
    check("zero_len_lo", 32'(cap[3]), 32'h14);
    check("zero_csum_hi", 32'(cap[10]), 32'h3A);
    check("zero_csum_lo", 32'(cap[11]), 32'hE5);

    // Random backpressure on the reference header.
    send_start(16'd95, 16'h0000, 8'h11, 32'hC0A8_0001, 32'hC0A8_00C7, 1'b1);
    cyc = 0;
    while (!done && cyc < 400) begin
      byte_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    if (!done) check("bp_timeout", 32'(done), 32'd1);
    byte_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("bp_xfers", 32'(xfers), 32'd20);
    check("bp_done_count", 32'(done_count), 32'd1);
    for (int i = 0; i < 20; i++) check($sformatf("bp_lit%0d", i), 32'(cap[i]), 32'(ref_bytes[i]));

    // Starts during SUM, SEND and DONE are ignored; start after done is taken.
    send_start(16'd95, 16'h0000, 8'h11, 32'hC0A8_0001, 32'hC0A8_00C7, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    send_start(16'd1, 16'h1111, 8'h01, 32'h0101_0101, 32'h0202_0202, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    check("send_phase", 32'(byte_valid), 32'd1);
    send_start(16'd2, 16'h2222, 8'h02, 32'h0303_0303, 32'h0404_0404, 1'b0);
    wait_done(100, cyc);
    send_start(16'd3, 16'h3333, 8'h03, 32'h0505_0505, 32'h0606_0606, 1'b0);
    check("ign_done_busy", 32'(busy), 32'd0);
    check("ign_xfers", 32'(xfers), 32'd20);
    check("ign_done_count", 32'(done_count), 32'd1);
    send_start(16'd200, 16'hBEEF, 8'h06, 32'h0A00_0001, 32'h0A00_0002, 1'b1);
    check("second_busy", 32'(busy), 32'd1);
    wait_done(100, cyc);
    tick();
    check("second_xfers", 32'(xfers), 32'd20);
    check("second_done_count", 32'(done_count), 32'd1);

    // Reset after byte 7 transfers aborts without done.
    send_start(16'd95, 16'h0000, 8'h11, 32'hC0A8_0001, 32'hC0A8_00C7, 1'b1);
    cyc = 0;
    while (mon_pos < 8 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("abort_reached", 32'(mon_pos >= 8), 32'd1);
    rst = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(byte_valid), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("abort_no_done", 32'(done_count), 32'd0);
    send_start(16'd0, 16'h0000, 8'h06, 32'h0, 32'h0, 1'b1);
    wait_done(100, cyc);
    tick();
    check("post_abort_xfers", 32'(xfers), 32'd20);
    check("post_abort_done", 32'(done_count), 32'd1);
    check("post_abort_csum", {16'd0, cap[10], cap[11]}, 32'h3AE5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
